// File: rtl/unstack_block_arbiter.sv
// Job controller and block arbiter in front of the 128->32 word unstacker.
// Define UNSTACK_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module unstack_block_arbiter #(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned BLOCK_WORDS = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clr_i,
    input  logic                   enable_i,
    input  logic                   start_i,
    input  logic [CNT_W-1:0]       nblocks_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [NUM_REQ*128-1:0] req_data_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic                   us_valid_o,
    output logic [127:0]           us_data_o,
    input  logic                   us_ready_i,
    input  logic                   word_valid_i,
    input  logic                   word_ready_i,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic [CNT_W-1:0]       remaining_o,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam int unsigned WCNT_W = $clog2(BLOCK_WORDS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_XFER,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [CNT_W-1:0]    rem_q, rem_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;

    logic [NUM_REQ-1:0]  pick;
    logic                any_req;
    logic                gvalid;
    logic [127:0]        gdata;
    logic                in_xfer;
    logic                word_hs;
    logic                last_word;
    logic                block_end;

    assign any_req   = |req_valid_i;
    assign gvalid    = |(grant_q & req_valid_i);
    assign in_xfer   = enable_i && (state_q == S_XFER);
    assign word_hs   = enable_i && word_valid_i && word_ready_i;
    assign last_word = (wcnt_q == WCNT_W'(BLOCK_WORDS - 1));
    assign block_end = (state_q == S_DRAIN) && word_hs && last_word;

    // Data of the currently granted requester (one-hot select)
    always_comb begin
        gdata = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant_q[i]) begin
                gdata = gdata | req_data_i[128*i +: 128];
            end
        end
    end

`ifdef UNSTACK_ARB_FIXED_PRIO_EN

    // Lowest-index valid requester wins
    always_comb begin
        logic found;
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            if (!found && req_valid_i[k]) begin
                pick[k] = 1'b1;
                found   = 1'b1;
            end
        end
    end

`else

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0]     rr_q, rr_d;
    logic [IDX_W-1:0]     gidx;
    logic [2*NUM_REQ-1:0] rv_dbl;
    logic [2*NUM_REQ-1:0] pick_dbl;
    logic [NUM_REQ-1:0]   rv_rot;
    logic [NUM_REQ-1:0]   pick_rot;

    // Encode the one-hot grant to an index for the pointer update
    always_comb begin
        gidx = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant_q[i]) begin
                gidx = IDX_W'(i);
            end
        end
    end

    // Round-robin: rotate requests to the pointer, pick first, rotate back
    always_comb begin
        logic found;
        found    = 1'b0;
        rv_dbl   = {req_valid_i, req_valid_i} >> rr_q;
        rv_rot   = rv_dbl[NUM_REQ-1:0];
        pick_rot = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            if (!found && rv_rot[k]) begin
                pick_rot[k] = 1'b1;
                found       = 1'b1;
            end
        end
        pick_dbl = {{NUM_REQ{1'b0}}, pick_rot} << rr_q;
        pick     = pick_dbl[NUM_REQ-1:0] | pick_dbl[2*NUM_REQ-1:NUM_REQ];
    end

    // Pointer moves past the requester whose block just drained
    always_comb begin
        rr_d = rr_q;
        if (clr_i) begin
            rr_d = '0;
        end else if (block_end) begin
            if (gidx == IDX_W'(NUM_REQ - 1)) begin
                rr_d = '0;
            end else begin
                rr_d = gidx + IDX_W'(1);
            end
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end

`endif

    // Next-state, grant, block and word counters
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rem_d   = rem_q;
        wcnt_d  = wcnt_q;
        if (clr_i) begin
            state_d = S_IDLE;
            grant_d = '0;
            rem_d   = '0;
            wcnt_d  = '0;
        end else if (enable_i) begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        if (nblocks_i != '0) begin
                            rem_d   = nblocks_i;
                            state_d = S_ARB;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_ARB: begin
                    if (any_req) begin
                        grant_d = pick;
                        state_d = S_XFER;
                    end
                end
                S_XFER: begin
                    if (!gvalid) begin
                        grant_d = '0;
                        state_d = S_ARB;
                    end else if (us_ready_i) begin
                        wcnt_d  = '0;
                        state_d = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (word_hs) begin
                        if (last_word) begin
                            wcnt_d  = '0;
                            grant_d = '0;
                            if (rem_q != '0) begin
                                rem_d = rem_q - CNT_W'(1);
                            end
                            if (rem_q <= CNT_W'(1)) begin
                                state_d = S_DONE;
                            end else begin
                                state_d = S_ARB;
                            end
                        end else begin
                            wcnt_d = wcnt_q + WCNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    grant_d = '0;
                    state_d = S_IDLE;
                end
                default: begin
                    grant_d = '0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and counter registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            rem_q   <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rem_q   <= rem_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Handshake outputs; valid only while enabled and the source is valid
    always_comb begin
        us_valid_o  = in_xfer && gvalid;
        us_data_o   = us_valid_o ? gdata : 128'd0;
        req_ready_o = in_xfer ? (grant_q & {NUM_REQ{us_ready_i}}) : '0;
        done_o      = enable_i && (state_q == S_DONE);
        busy_o      = (state_q != S_IDLE);
        grant_o     = grant_q;
        remaining_o = rem_q;
    end

endmodule

// File: tb/tb_unstack_block_arbiter.sv
// Directed bench for unstack_block_arbiter.
// Honors UNSTACK_ARB_FIXED_PRIO_EN for expected grant order.
module tb_unstack_block_arbiter;

    localparam int NR = 2;
    localparam int CW = 16;

    localparam logic [127:0] D0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] D1 = 128'hA5A5A5A5_5A5A5A5A_01234567_89ABCDEF;

`ifdef UNSTACK_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clr = 1'b0;
    logic              en = 1'b1;
    logic              start = 1'b0;
    logic [CW-1:0]     nb = '0;
    logic [NR-1:0]     rv = '0;
    logic [NR*128-1:0] rd;
    logic [NR-1:0]     rr;
    logic              us_valid;
    logic [127:0]      us_data;
    logic              us_ready = 1'b0;
    logic              wv = 1'b0;
    logic              wr = 1'b0;
    logic [NR-1:0]     grant;
    logic [CW-1:0]     remaining;
    logic              busy;
    logic              done;

    int checks = 0;
    int failures = 0;
    int ngr;
    int ndone;
    logic [NR-1:0] gseq [8];

    assign rd = {D1, D0};

    unstack_block_arbiter #(
        .NUM_REQ(NR),
        .BLOCK_WORDS(4),
        .CNT_W(CW)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .clr_i(clr),
        .enable_i(en),
        .start_i(start),
        .nblocks_i(nb),
        .req_valid_i(rv),
        .req_data_i(rd),
        .req_ready_o(rr),
        .us_valid_o(us_valid),
        .us_data_o(us_data),
        .us_ready_i(us_ready),
        .word_valid_i(wv),
        .word_ready_i(wr),
        .grant_o(grant),
        .remaining_o(remaining),
        .busy_o(busy),
        .done_o(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    // Runs one job to IDLE, logging accepted-block grants and done pulses
    task automatic run_job(input logic [CW-1:0] n);
        ngr = 0;
        ndone = 0;
        start = 1'b1;
        nb = n;
        step();
        start = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (us_valid && us_ready) begin
                if (ngr < 8) gseq[ngr] = grant;
                ngr++;
            end
            if (done) ndone++;
            if (!busy) break;
            step();
        end
        chk("job_end_busy", busy, 0);
    endtask

    initial begin
        // ---- reset state
        steps(2);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_rem", remaining, 0);
        chk("rst_usv", us_valid, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        step();

        // ---- 1: single block from req0
        rv = 2'b01;
        us_ready = 1'b1;
        start = 1'b1;
        nb = 16'd1;
        step();
        start = 1'b0;
        chk("t1_arb_usv", us_valid, 0);
        chk("t1_arb_rem", remaining, 1);
        step();
        chk("t1_grant", grant, 2'b01);
        chk("t1_usv", us_valid, 1);
        chk("t1_data", us_data, D0);
        chk("t1_rdy", rr, 2'b01);
        step();
        chk("t1_drain_usv", us_valid, 0);
        chk("t1_drain_data", us_data, 0);
        wv = 1'b1;
        wr = 1'b1;
        steps(3);
        chk("t1_3w_done", done, 0);
        step();
        chk("t1_done", done, 1);
        chk("t1_done_rem", remaining, 0);
        step();
        chk("t1_idle_done", done, 0);
        chk("t1_idle_busy", busy, 0);

        // ---- 2: two always-valid requesters, four blocks
        do_clr();
        rv = 2'b11;
        run_job(16'd4);
        chk("t2_ngr", ngr, 4);
        chk("t2_ndone", ndone, 1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_g%0d", i), gseq[i],
                (FIXED || (i % 2 == 0)) ? 2'b01 : 2'b10);
        end

        // ---- 3: word_ready stalled during DRAIN
        do_clr();
        rv = 2'b01;
        wv = 1'b1;
        wr = 1'b0;
        start = 1'b1;
        nb = 16'd2;
        step();
        start = 1'b0;
        steps(2);
        chk("t3_drain_grant", grant, 2'b01);
        wr = 1'b1;
        steps(2);
        wr = 1'b0;
        rv = 2'b11;
        steps(10);
        chk("t3_stall_grant", grant, 2'b01);
        chk("t3_stall_usv", us_valid, 0);
        chk("t3_stall_rem", remaining, 2);
        wr = 1'b1;
        steps(2);
        chk("t3_arb_grant", grant, 0);
        chk("t3_arb_rem", remaining, 1);
        step();
        chk("t3_g2", grant, FIXED ? 2'b01 : 2'b10);
        chk("t3_data2", us_data, FIXED ? D0 : D1);
        steps(5);
        chk("t3_done", done, 1);
        step();
        chk("t3_idle", busy, 0);

        // ---- 4: zero-block job
        run_job(16'd0);
        chk("t4_ndone", ndone, 1);
        chk("t4_ngr", ngr, 0);

        // ---- 5: enable low in XFER, clr in DRAIN
        do_clr();
        rv = 2'b01;
        wv = 1'b1;
        wr = 1'b1;
        start = 1'b1;
        nb = 16'd3;
        step();
        start = 1'b0;
        step();
        en = 1'b0;
        #1;
        chk("t5_dis_usv", us_valid, 0);
        chk("t5_dis_rdy", rr, 0);
        steps(5);
        chk("t5_hold_usv", us_valid, 0);
        chk("t5_hold_grant", grant, 2'b01);
        chk("t5_hold_rem", remaining, 3);
        chk("t5_hold_busy", busy, 1);
        en = 1'b1;
        #1;
        chk("t5_reen_usv", us_valid, 1);
        step();
        step();
        en = 1'b0;
        steps(3);
        en = 1'b1;
        steps(2);
        chk("t5_words_grant", grant, 2'b01);
        chk("t5_words_rem", remaining, 3);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("t5_clr_busy", busy, 0);
        chk("t5_clr_rem", remaining, 0);
        chk("t5_clr_grant", grant, 0);

        // ---- 6: async reset mid-DRAIN, then clean job
        wr = 1'b0;
        start = 1'b1;
        nb = 16'd2;
        step();
        start = 1'b0;
        steps(2);
        wr = 1'b1;
        steps(2);
        wr = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_grant", grant, 0);
        chk("t6_rst_rem", remaining, 0);
        rst = 1'b0;
        step();
        start = 1'b1;
        nb = 16'd1;
        step();
        start = 1'b0;
        steps(2);
        wr = 1'b1;
        steps(3);
        chk("t6_3w_grant", grant, 2'b01);
        chk("t6_3w_done", done, 0);
        step();
        chk("t6_done", done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
